// File: rtl/arm_decode_stage_if.sv
// Fetch-side and decode-side bus of arm_decode_stage.
// Optional stat_* signals exist only when DECODE_STATS_EN is defined.
interface arm_decode_stage_if #(
  parameter int OFF_W  = 32,
  parameter int STAT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instruction;
  logic             out_valid;
  logic             out_ready;
  logic [2:0]       fmt;
  logic [3:0]       opcode;
  logic             s_bit;
  logic [3:0]       ra;
  logic [3:0]       rc;
  logic [3:0]       rb;
  logic [3:0]       rotate_imm;
  logic [7:0]       immediate;
  logic [1:0]       shift;
  logic [4:0]       shift_imm;
  logic [4:0]       ls_pubwl;
  logic [11:0]      imm12;
  logic             link;
  logic [OFF_W-1:0] branch_off;
  logic             sel;
  logic             shifter_en;
  logic             rotator_en;
  logic             registerFile_en;
  logic             illegal;
`ifdef DECODE_STATS_EN
  logic [STAT_W-1:0] stat_retired;
  logic [STAT_W-1:0] stat_illegal;
`endif

  modport master (
`ifdef DECODE_STATS_EN
    input  stat_retired, stat_illegal,
`endif
    output in_valid, instruction, out_ready,
    input  in_ready, out_valid, fmt, opcode,
    input  s_bit, ra, rc, rb, rotate_imm,
    input  immediate, shift, shift_imm,
    input  ls_pubwl, imm12, link, branch_off,
    input  sel, shifter_en, rotator_en,
    input  registerFile_en, illegal
  );

  modport slave (
`ifdef DECODE_STATS_EN
    output stat_retired, stat_illegal,
`endif
    input  in_valid, instruction, out_ready,
    output in_ready, out_valid, fmt, opcode,
    output s_bit, ra, rc, rb, rotate_imm,
    output immediate, shift, shift_imm,
    output ls_pubwl, imm12, link, branch_off,
    output sel, shifter_en, rotator_en,
    output registerFile_en, illegal
  );
endinterface

// File: rtl/arm_decode_stage.sv
// Registered ARM decode stage with 2-entry skid buffer and flush.
// Define DECODE_STATS_EN to add saturating retired/illegal counters.
module arm_decode_stage #(
  parameter int OFF_W  = 32,
  parameter int STAT_W = 16
) (
  input logic               clk,
  input logic               rst_n,
  input logic               flush,
  arm_decode_stage_if.slave bus
);

  typedef struct packed {
    logic [31:0] word;
    logic        sel;
    logic        shifter_en;
    logic        rotator_en;
    logic        rf_n;
    logic        illegal;
  } entry_t;

  localparam entry_t RST = '{
    word: 32'd0, sel: 1'b0, shifter_en: 1'b0,
    rotator_en: 1'b0, rf_n: 1'b1, illegal: 1'b0
  };

  function automatic entry_t decode(
    input logic [31:0] w
  );
    entry_t     e;
    logic [2:0] f;
    f = w[27:25];
    e = RST;
    e.word = w;
    unique case (1'b1)
      f == 3'b000: begin
        e.sel        = 1'b1;
        e.shifter_en = 1'b1;
        e.rf_n       = 1'b0;
      end
      f == 3'b001: begin
        e.rotator_en = 1'b1;
        e.rf_n       = 1'b0;
      end
      f == 3'b010: e.rf_n = 1'b0;
      f == 3'b011: begin
        e.sel        = 1'b1;
        e.shifter_en = 1'b1;
        e.rf_n       = 1'b0;
      end
      f == 3'b101: e.rf_n = !w[24];
      default:     e.illegal = 1'b1;
    endcase
    return e;
  endfunction

  entry_t out_q;
  entry_t skid_q;
  entry_t dec;
  logic   out_v;
  logic   skid_v;
  logic   accept;
  logic   drain;
  logic   xfer;

  assign dec    = decode(bus.instruction);
  assign accept = bus.in_valid & !skid_v;
  assign drain  = !out_v | bus.out_ready;
  assign xfer   = out_v & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q  <= RST;
      skid_q <= RST;
      out_v  <= 1'b0;
      skid_v <= 1'b0;
    end else if (flush) begin
      out_v  <= 1'b0;
      skid_v <= 1'b0;
    end else if (drain) begin
      if (skid_v) begin
        out_q  <= skid_q;
        out_v  <= 1'b1;
        skid_v <= accept;
        if (accept) skid_q <= dec;
      end else begin
        out_v <= accept;
        if (accept) out_q <= dec;
      end
    end else if (accept) begin
      skid_q <= dec;
      skid_v <= 1'b1;
    end
  end

  logic [31:0] w;
  logic [31:0] off_full;

  assign w        = out_q.word;
  assign off_full = {{6{w[23]}}, w[23:0], 2'b00};

  assign bus.in_ready        = !skid_v;
  assign bus.out_valid       = out_v;
  assign bus.fmt             = w[27:25];
  assign bus.opcode          = w[24:21];
  assign bus.s_bit           = w[20];
  assign bus.ra              = w[19:16];
  assign bus.rc              = w[15:12];
  assign bus.rb              = w[3:0];
  assign bus.rotate_imm      = w[11:8];
  assign bus.immediate       = w[7:0];
  assign bus.shift           = w[6:5];
  assign bus.shift_imm       = w[11:7];
  assign bus.ls_pubwl        = w[24:20];
  assign bus.imm12           = w[11:0];
  assign bus.link            = w[24];
  assign bus.branch_off      = off_full[OFF_W-1:0];
  assign bus.sel             = out_q.sel;
  assign bus.shifter_en      = out_q.shifter_en;
  assign bus.rotator_en      = out_q.rotator_en;
  assign bus.registerFile_en = out_q.rf_n;
  assign bus.illegal         = out_q.illegal;

  logic unused_bits;
  assign unused_bits = ^{w[31:28], off_full};

`ifdef DECODE_STATS_EN
  logic [STAT_W-1:0] ret_q;
  logic [STAT_W-1:0] ill_q;

  // Counters saturate and deliberately ignore flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ret_q <= '0;
      ill_q <= '0;
    end else if (xfer) begin
      if (ret_q != '1) ret_q <= ret_q + 1'b1;
      if (out_q.illegal && ill_q != '1)
        ill_q <= ill_q + 1'b1;
    end
  end

  assign bus.stat_retired = ret_q;
  assign bus.stat_illegal = ill_q;
`else
  logic unused_xfer;
  logic [STAT_W-1:0] unused_stat;
  assign unused_xfer = xfer;
  assign unused_stat = '0;
`endif

endmodule

// File: tb/tb_arm_decode_stage.sv
// Scoreboard bench for arm_decode_stage: directed vectors,
// backpressure, skid fill and flush.
module tb_arm_decode_stage;
  localparam int OFF_W  = 32;
  localparam int STAT_W = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  arm_decode_stage_if #(.OFF_W(OFF_W), .STAT_W(STAT_W)) bus ();

  arm_decode_stage #(.OFF_W(OFF_W), .STAT_W(STAT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  typedef struct packed {
    logic [2:0]  fmt;
    logic [3:0]  opcode;
    logic        s_bit;
    logic [3:0]  ra;
    logic [3:0]  rc;
    logic [3:0]  rb;
    logic [3:0]  rotate_imm;
    logic [7:0]  immediate;
    logic [1:0]  shift;
    logic [4:0]  shift_imm;
    logic [4:0]  ls_pubwl;
    logic [11:0] imm12;
    logic        link;
    logic [31:0] branch_off;
    logic        sel;
    logic        shifter_en;
    logic        rotator_en;
    logic        rf_en;
    logic        illegal;
  } exp_t;

  typedef struct {
    logic [31:0] word;
    exp_t        e;
  } sb_t;

  sb_t         sb[$];
  int          total  = 0;
  int          passed = 0;
  exp_t        vec[8];
  logic [31:0] wrd[8];

  task automatic chk(input string n,
                     input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %h want %h", n, a, e);
  endtask

  always @(negedge clk) begin
    exp_t act;
    sb_t  s;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      act = '{bus.fmt, bus.opcode, bus.s_bit, bus.ra,
              bus.rc, bus.rb, bus.rotate_imm,
              bus.immediate, bus.shift, bus.shift_imm,
              bus.ls_pubwl, bus.imm12, bus.link,
              bus.branch_off, bus.sel, bus.shifter_en,
              bus.rotator_en, bus.registerFile_en,
              bus.illegal};
      total++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_out: got %h want none", act);
      end else begin
        s = sb.pop_front();
        if (act === s.e) passed++;
        else $display("FAIL bundle_%h: got %h want %h",
                      s.word, act, s.e);
      end
    end
  end

  task automatic send(input int i);
    int n;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) chk("send_timeout", 32'd1, 32'd0);
    bus.in_valid    = 1'b1;
    bus.instruction = wrd[i];
    @(posedge clk);
    sb.push_back('{wrd[i], vec[i]});
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) chk("drain_timeout", sb.size(), 32'd0);
  endtask

  initial begin
    wrd[0] = 32'hE0821003;
    vec[0] = '{3'd0, 4'h4, 1'b0, 4'h2, 4'h1, 4'h3, 4'h0,
               8'h03, 2'd0, 5'h00, 5'h08, 12'h003, 1'b0,
               32'hFE08400C, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    wrd[1] = 32'hE3A000FF;
    vec[1] = '{3'd1, 4'hD, 1'b0, 4'h0, 4'h0, 4'hF, 4'h0,
               8'hFF, 2'd3, 5'h01, 5'h1A, 12'h0FF, 1'b1,
               32'hFE8003FC, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    wrd[2] = 32'hEBFFFFFE;
    vec[2] = '{3'd5, 4'hF, 1'b1, 4'hF, 4'hF, 4'hE, 4'hF,
               8'hFE, 2'd3, 5'h1F, 5'h1F, 12'hFFE, 1'b1,
               32'hFFFFFFF8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    wrd[3] = 32'hEAFFFFFE;
    vec[3] = '{3'd5, 4'h7, 1'b1, 4'hF, 4'hF, 4'hE, 4'hF,
               8'hFE, 2'd3, 5'h1F, 5'h0F, 12'hFFE, 1'b0,
               32'hFFFFFFF8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    wrd[4] = 32'hE5912004;
    vec[4] = '{3'd2, 4'hC, 1'b1, 4'h1, 4'h2, 4'h4, 4'h0,
               8'h04, 2'd0, 5'h00, 5'h19, 12'h004, 1'b1,
               32'hFE448010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    wrd[5] = 32'hE7912103;
    vec[5] = '{3'd3, 4'hC, 1'b1, 4'h1, 4'h2, 4'h3, 4'h1,
               8'h03, 2'd0, 5'h02, 5'h19, 12'h103, 1'b1,
               32'hFE44840C, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    wrd[6] = 32'hEE000000;
    vec[6] = '{3'd7, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0,
               8'h00, 2'd0, 5'h00, 5'h00, 12'h000, 1'b0,
               32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    wrd[7] = 32'hE8000000;
    vec[7] = '{3'd4, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0,
               8'h00, 2'd0, 5'h00, 5'h00, 12'h000, 1'b0,
               32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    bus.in_valid    = 1'b0;
    bus.instruction = 32'd0;
    bus.out_ready   = 1'b0;

    #12;
    chk("rst_out_valid", bus.out_valid, 32'd0);
    chk("rst_rf_en", bus.registerFile_en, 32'd1);
    chk("rst_fmt", bus.fmt, 32'd0);
    chk("rst_branch_off", bus.branch_off, 32'd0);
    chk("rst_sel", bus.sel, 32'd0);
    #5 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", bus.in_ready, 32'd1);

    // Streaming: one-cycle latency, all formats.
    bus.out_ready = 1'b1;
    send(0);
    chk("latency_valid", bus.out_valid, 32'd1);
    for (int i = 1; i < 8; i++) send(i);
    wait_empty();
    @(posedge clk); #1;
    chk("idle_valid", bus.out_valid, 32'd0);

    // Backpressure fills the skid slot.
    bus.out_ready = 1'b0;
    send(0);
    send(1);
    chk("skid_full_in_ready", bus.in_ready, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_valid", bus.out_valid, 32'd1);
    chk("hold_opcode", bus.opcode, 32'h4);
    chk("hold_rc", bus.rc, 32'h1);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("drain1_valid", bus.out_valid, 32'd1);
    chk("drain1_opcode", bus.opcode, 32'hD);
    chk("drain1_in_ready", bus.in_ready, 32'd1);
    @(posedge clk); #1;
    chk("drain2_valid", bus.out_valid, 32'd0);
    chk("drain_sb_empty", sb.size(), 32'd0);

    // Flush with skid full and a word offered.
    bus.out_ready = 1'b0;
    send(2);
    send(3);
    chk("pre_flush_in_ready", bus.in_ready, 32'd0);
    flush           = 1'b1;
    bus.in_valid    = 1'b1;
    bus.instruction = wrd[4];
    @(posedge clk);
    sb.delete();
    #1;
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_valid", bus.out_valid, 32'd0);
    chk("flush_in_ready", bus.in_ready, 32'd1);
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("flush_no_leak", bus.out_valid, 32'd0);

    // Flush beats a same-cycle accept.
    bus.out_ready = 1'b0;
    send(5);
    flush           = 1'b1;
    bus.in_valid    = 1'b1;
    bus.instruction = wrd[6];
    @(posedge clk);
    sb.delete();
    #1;
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush2_valid", bus.out_valid, 32'd0);
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("flush2_no_leak", bus.out_valid, 32'd0);

    // Post-flush traffic still flows in order.
    send(6);
    send(0);
    wait_empty();
    @(posedge clk); #1;

`ifdef DECODE_STATS_EN
    chk("stat_retired", bus.stat_retired, 32'd12);
    chk("stat_illegal", bus.stat_illegal, 32'd3);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
